// File: rtl/mod_n_count_arbiter_if.sv
// Request/grant bundle between two requesters, a shared mod-N counter and the arbiter.
// master = requester/counter side, slave = arbiter side.
interface mod_n_count_arbiter_if #(
  parameter int WIDTH = 2,
  parameter int LEN_W = 4
);
  logic [1:0]       i_req;
  logic [1:0]       i_dir;
  logic [LEN_W-1:0] i_len0;
  logic [LEN_W-1:0] i_len1;
  logic [WIDTH-1:0] i_Q;
  logic [1:0]       o_gnt;
  logic [1:0]       o_done;
  logic             o_clr;
  logic             o_en;
  logic             o_up_down;
  logic [LEN_W-1:0] o_wraps;

  modport master (
    output i_req, i_dir, i_len0, i_len1, i_Q,
    input  o_gnt, o_done, o_clr, o_en, o_up_down, o_wraps
  );

  modport slave (
    input  i_req, i_dir, i_len0, i_len1, i_Q,
    output o_gnt, o_done, o_clr, o_en, o_up_down, o_wraps
  );
endinterface

// File: rtl/mod_n_count_arbiter.sv
// Round-robin arbiter that lends a shared mod-N counter to one of two requesters
// for a captured run length and counts counter wraps during the run.
//
// state | meaning
// IDLE  | no owner; grant on any request
// CLR   | owner granted, counter cleared for one cycle
// RUN   | counter enabled, run-length down-counter active
// DONE  | one-cycle completion pulse, then release
module mod_n_count_arbiter #(
  parameter int WIDTH = 2,
  parameter int N     = 3,
  parameter int LEN_W = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  mod_n_count_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CLR  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(N - 1);

  logic [1:0]       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             gidx_q, gidx_d;
  logic             dir_q, dir_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] wraps_q, wraps_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic             clr_q, clr_d;
  logic             en_q, en_d;
  logic             ud_q, ud_d;
  logic             sel;
  logic             wrap_hit;
  logic             req_g;
  logic [1:0]       gnt_sel;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    dir_d    = dir_q;
    rem_d    = rem_q;
    wraps_d  = wraps_q;
    sel      = bus.i_req[ptr_q] ? ptr_q : ~ptr_q;
    wrap_hit = dir_q ? (bus.i_Q == Q_MAX) : (bus.i_Q == '0);
    req_g    = bus.i_req[gidx_q];

    case (state_q)
      S_IDLE: begin
        if (|bus.i_req) begin
          gidx_d  = sel;
          dir_d   = bus.i_dir[sel];
          rem_d   = sel ? bus.i_len1 : bus.i_len0;
          wraps_d = '0;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        if (!req_g) begin
          ptr_d   = ~gidx_q;
          state_d = S_IDLE;
        end else if (rem_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // every RUN cycle drives o_en, so a wrap seen here is a real counter wrap
        if (wrap_hit && (wraps_q != '1)) wraps_d = wraps_q + LEN_W'(1);
        rem_d = rem_q - LEN_W'(1);
        if (!req_g) begin
          ptr_d   = ~gidx_q;
          state_d = S_IDLE;
        end else if (rem_q == LEN_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ptr_d   = ~gidx_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // outputs are registered copies decoded from the next state
    gnt_sel = gidx_d ? 2'b10 : 2'b01;
    gnt_d   = (state_d != S_IDLE) ? gnt_sel : 2'b00;
    done_d  = (state_d == S_DONE) ? gnt_sel : 2'b00;
    clr_d   = (state_d == S_CLR);
    en_d    = (state_d == S_RUN);
    ud_d    = (state_d == S_RUN) && dir_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      gidx_q  <= 1'b0;
      dir_q   <= 1'b0;
      rem_q   <= '0;
      wraps_q <= '0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      ud_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      wraps_q <= wraps_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      clr_q   <= clr_d;
      en_q    <= en_d;
      ud_q    <= ud_d;
    end
  end

  assign bus.o_gnt     = gnt_q;
  assign bus.o_done    = done_q;
  assign bus.o_clr     = clr_q;
  assign bus.o_en      = en_q;
  assign bus.o_up_down = ud_q;
  assign bus.o_wraps   = wraps_q;

endmodule

// File: tb/tb_mod_n_count_arbiter.sv
// Bench for mod_n_count_arbiter: drives two requesters against a real mod-3 counter
// and checks runs from a vector table, hand sequences and a randomized arithmetic model.
module tb_mod_n_count_arbiter;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] cnt_q;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_no  = 0;
  int clr_tick = 0;
  int en_cnt   = 0;

  mod_n_count_arbiter_if #(.WIDTH(2), .LEN_W(4)) bus ();

  mod_n_count_arbiter #(.WIDTH(2), .N(N), .LEN_W(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // shared mod-N counter owned by whoever holds the grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt_q <= 2'd0;
    else if (bus.o_clr)    cnt_q <= 2'd0;
    else if (bus.o_en) begin
      if (bus.o_up_down)   cnt_q <= (cnt_q == 2'(N - 1)) ? 2'd0 : cnt_q + 2'd1;
      else                 cnt_q <= (cnt_q == 2'd0) ? 2'(N - 1) : cnt_q - 2'd1;
    end
  end
  assign bus.i_Q = cnt_q;

  typedef struct {
    logic [1:0] req;
    int g;
    int dir;
    int len;
    int exp_q;
    int exp_w;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // one clock; invariants that hold on every cycle are checked here
  task automatic tick();
    @(negedge clk);
    tick_no++;
    chk("gnt_onehot", int'($countones(bus.o_gnt) <= 1), 1);
    chk("done_within_gnt", int'(bus.o_done & ~bus.o_gnt), 0);
    if (bus.o_done != 2'b00) chk("done_en_low", int'(bus.o_en), 0);
    if (bus.o_clr) begin
      chk("clr_wraps_zero", int'(bus.o_wraps), 0);
      en_cnt   = 0;
      clr_tick = tick_no;
    end
    if (bus.o_en) en_cnt++;
  endtask

  function automatic int model_q(input int dir, input int len);
    if (dir != 0) return len % N;
    return (N - (len % N)) % N;
  endfunction

  function automatic int model_w(input int dir, input int len);
    int w;
    w = (dir != 0) ? len / N : (len + N - 1) / N;
    return (w > 15) ? 15 : w;
  endfunction

  task automatic serve(input int g, input int dir, input int len,
                       input int exp_q, input int exp_w, input bit scramble);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      tick();
      if (bus.o_done != 2'b00) got = 1'b1;
      else begin
        if (bus.o_en) chk("up_down", int'(bus.o_up_down), dir);
        if (scramble && bus.o_clr) begin
          bus.i_dir[g] = 1'($urandom_range(0, 1));
          if (g == 1) bus.i_len1 = 4'($urandom_range(0, 15));
          else        bus.i_len0 = 4'($urandom_range(0, 15));
        end
      end
    end
    chk("done_timeout", int'(got), 1);
    chk("done_vec", int'(bus.o_done), 1 << g);
    chk("done_gnt_held", int'(bus.o_gnt), 1 << g);
    chk("final_q", int'(bus.i_Q), exp_q);
    chk("wraps", int'(bus.o_wraps), exp_w);
    chk("en_cycles", en_cnt, len);
    chk("latency", tick_no - clr_tick, len + 1);
    bus.i_req[g] = 1'b0;
    tick();
    chk("idle_gnt", int'(bus.o_gnt), 0);
    chk("wraps_hold", int'(bus.o_wraps), exp_w);
  endtask

  task automatic wait_clr();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      if (bus.o_clr) got = 1'b1;
    end
    chk("clr_timeout", int'(got), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pending[2];
    int dir_m[2];
    int len_m[2];
    int ptr_m;
    int w;

    vecs[0] = '{2'b01, 0, 1, 5,  2, 1};
    vecs[1] = '{2'b10, 1, 0, 4,  2, 2};
    vecs[2] = '{2'b10, 1, 1, 0,  0, 0};
    vecs[3] = '{2'b01, 0, 0, 3,  0, 1};
    vecs[4] = '{2'b01, 0, 1, 15, 0, 5};
    vecs[5] = '{2'b10, 1, 1, 1,  1, 0};
    vecs[6] = '{2'b10, 1, 0, 6,  0, 2};

    // reset with both requesting: nothing may be granted
    bus.i_req = 2'b11; bus.i_dir = 2'b01; bus.i_len0 = 4'd5; bus.i_len1 = 4'd4;
    repeat (2) tick();
    chk("rst_gnt",   int'(bus.o_gnt), 0);
    chk("rst_done",  int'(bus.o_done), 0);
    chk("rst_clr",   int'(bus.o_clr), 0);
    chk("rst_en",    int'(bus.o_en), 0);
    chk("rst_ud",    int'(bus.o_up_down), 0);
    chk("rst_wraps", int'(bus.o_wraps), 0);
    #2 rst_n = 1'b1;

    // both at once after reset: requester 0 first, then 1
    serve(0, 1, 5, 2, 1, 1'b0);
    serve(1, 0, 4, 2, 2, 1'b0);

    foreach (vecs[i]) begin
      if (vecs[i].g == 1) begin
        bus.i_dir[1] = 1'(vecs[i].dir); bus.i_len1 = 4'(vecs[i].len);
      end else begin
        bus.i_dir[0] = 1'(vecs[i].dir); bus.i_len0 = 4'(vecs[i].len);
      end
      bus.i_req = vecs[i].req;
      serve(vecs[i].g, vecs[i].dir, vecs[i].len, vecs[i].exp_q, vecs[i].exp_w, 1'b0);
    end

    // abort: requester 1 drops on its second RUN cycle while 0 waits
    bus.i_dir[0] = 1'b1; bus.i_len0 = 4'd2; bus.i_req = 2'b01;
    serve(0, 1, 2, 2, 0, 1'b0);
    bus.i_dir = 2'b10; bus.i_len0 = 4'd3; bus.i_len1 = 4'd6; bus.i_req = 2'b11;
    wait_clr();
    chk("abort_gnt1", int'(bus.o_gnt), 2);
    tick(); chk("abort_run1_en", int'(bus.o_en), 1);
    tick(); chk("abort_run2_en", int'(bus.o_en), 1);
    bus.i_req[1] = 1'b0;
    tick();
    chk("abort_en",   int'(bus.o_en), 0);
    chk("abort_gnt",  int'(bus.o_gnt), 0);
    chk("abort_done", int'(bus.o_done), 0);
    tick();
    chk("after_abort_gnt", int'(bus.o_gnt), 1);
    chk("after_abort_clr", int'(bus.o_clr), 1);
    serve(0, 0, 3, 0, 1, 1'b0);

    // async reset between edges in the middle of a run
    bus.i_dir[0] = 1'b1; bus.i_len0 = 4'd10; bus.i_req = 2'b01;
    wait_clr();
    repeat (3) tick();
    chk("pre_rst_en", int'(bus.o_en), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_gnt",   int'(bus.o_gnt), 0);
    chk("midrst_done",  int'(bus.o_done), 0);
    chk("midrst_clr",   int'(bus.o_clr), 0);
    chk("midrst_en",    int'(bus.o_en), 0);
    chk("midrst_ud",    int'(bus.o_up_down), 0);
    chk("midrst_wraps", int'(bus.o_wraps), 0);
    bus.i_dir[1] = 1'b1; bus.i_len1 = 4'd2; bus.i_req = 2'b11;
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_gnt", int'(bus.o_gnt), 1);
    serve(0, 1, 10, 1, 3, 1'b0);
    serve(1, 1, 2, 2, 0, 1'b0);

    // randomized traffic against the arithmetic model
    bus.i_req = 2'b00;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    pending[0] = 1'b0; pending[1] = 1'b0;
    ptr_m = 0;
    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pending[r] && ($urandom_range(0, 1) == 1)) begin
          pending[r] = 1'b1;
          dir_m[r] = int'($urandom_range(0, 1));
          len_m[r] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
        end
      end
      if (!pending[0] && !pending[1]) begin
        w = int'($urandom_range(0, 1));
        pending[w] = 1'b1; dir_m[w] = 1; len_m[w] = int'($urandom_range(0, 15));
      end
      bus.i_dir[0] = 1'(dir_m[0]); bus.i_len0 = 4'(len_m[0]);
      bus.i_dir[1] = 1'(dir_m[1]); bus.i_len1 = 4'(len_m[1]);
      bus.i_req = {pending[1], pending[0]};
      w = pending[ptr_m] ? ptr_m : 1 - ptr_m;
      serve(w, dir_m[w], len_m[w], model_q(dir_m[w], len_m[w]), model_w(dir_m[w], len_m[w]), 1'b1);
      pending[w] = 1'b0;
      dir_m[w] = int'(bus.i_dir[w]);
      len_m[w] = (w == 1) ? int'(bus.i_len1) : int'(bus.i_len0);
      ptr_m = 1 - w;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
